// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU command sequencer: opcodes, FSM states,
// command entry layout and sticky flag bit positions.
package fpu_seq_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_SQRT  = 3'd3;
    localparam logic [2:0] OP_CMP   = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD1,
        S_LOAD2,
        S_EXEC,
        S_ABORT
    } state_e;

    // Command entry is {op, rd, rs1, rs2, data}
    localparam int CMD_W    = 50;
    localparam int DATA_LSB = 0;
    localparam int RS2_LSB  = 32;
    localparam int RS1_LSB  = 37;
    localparam int RD_LSB   = 42;
    localparam int OP_LSB   = 47;

    localparam int FL_OV       = 0;
    localparam int FL_UN       = 1;
    localparam int FL_INV      = 2;
    localparam int FL_INEXACT  = 3;
    localparam int FL_DIV_ZERO = 4;
    localparam int FL_ILLEGAL  = 5;
    localparam int FL_TIMEOUT  = 6;

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; also reports next-cycle
// full/empty so the owner can register its ready and busy outputs.
module fpu_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstp,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_next_o,
    output logic         empty_next_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q, wr_d, rd_d;
    logic [W-1:0] mem_q [DEPTH];

    function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    assign wr_d         = wr_q + {{AW{1'b0}}, push_i};
    assign rd_d         = rd_q + {{AW{1'b0}}, pop_i};
    assign empty_o      = (wr_q == rd_q);
    assign empty_next_o = (wr_d == rd_d);
    assign full_next_o  = is_full(wr_d, rd_d);
    assign rdata_o      = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fpu_seq.sv
// Sequences buffered host commands onto the FPU control pins and returns
// results, compare outcome and sticky exception flags.
module fpu_seq
    import fpu_seq_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter int         TIMEOUT   = 32,
    parameter logic [4:0] PARK_ADDR = 5'd31
) (
    input  logic        clk,
    input  logic        rstp,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [31:0] cmd_data,
    output logic [4:0]  fpu_addr1,
    output logic [4:0]  fpu_addr2,
    output logic [4:0]  fpu_addr3,
    output logic [2:0]  fpu_opcode,
    output logic        fpu_enable,
    output logic        fpu_ld,
    output logic        fpu_act,
    output logic [31:0] fpu_inp,
    input  logic [31:0] fpu_out,
    input  logic        fpu_done,
    input  logic        fpu_ov,
    input  logic        fpu_un,
    input  logic        fpu_inv,
    input  logic        fpu_inexact,
    input  logic        fpu_div_zero,
    input  logic        fpu_eq,
    input  logic        fpu_less,
    input  logic        fpu_great,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_cmp,
    output logic        rsp_err,
    output logic [6:0]  flags,
    input  logic        clr_flags,
    output logic        busy
);

    state_e           state_q, state_d;
    logic [5:0]       cnt_q;
    logic [CMD_W-1:0] cur_q, sel, fifo_rdata;
    logic             push, pop, fifo_empty, fifo_full_next, fifo_empty_next;
    logic [6:0]       flag_set;

    // Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are both high.
    assign push = cmd_valid && cmd_ready;

    fpu_seq_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rstp        (rstp),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     ({cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_data}),
        .rdata_o     (fifo_rdata),
        .empty_o     (fifo_empty),
        .full_next_o (fifo_full_next),
        .empty_next_o(fifo_empty_next)
    );

    // Fields driven onto the FPU come from the head entry on the pop cycle.
    assign sel = pop ? fifo_rdata : cur_q;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        flag_set = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (fifo_rdata[OP_LSB +: 3])
                        OP_STORE: state_d = S_STORE;
                        OP_ADD, OP_MUL, OP_DIV, OP_SQRT, OP_CMP: state_d = S_LOAD1;
                        default: flag_set[FL_ILLEGAL] = 1'b1;
                    endcase
                end
            end
            S_STORE: state_d = S_IDLE;
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: state_d = S_EXEC;
            S_EXEC: begin
                if (fpu_done) begin
                    state_d                 = S_IDLE;
                    flag_set[FL_OV]         = fpu_ov;
                    flag_set[FL_UN]         = fpu_un;
                    flag_set[FL_INV]        = fpu_inv;
                    flag_set[FL_INEXACT]    = fpu_inexact;
                    flag_set[FL_DIV_ZERO]   = fpu_div_zero;
                end else if (cnt_q == 6'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                state_d               = S_IDLE;
                flag_set[FL_TIMEOUT]  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            flags      <= '0;
            fpu_enable <= 1'b0;
            fpu_ld     <= 1'b0;
            fpu_act    <= 1'b0;
            fpu_addr1  <= PARK_ADDR;
            fpu_addr2  <= '0;
            fpu_addr3  <= '0;
            fpu_opcode <= '0;
            fpu_inp    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cmp    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= !fifo_full_next;
            busy      <= (state_d != S_IDLE) || !fifo_empty_next;
            flags     <= clr_flags ? 7'd0 : (flags | flag_set);
            if (pop) cur_q <= fifo_rdata;
            // Zero outside EXEC so it always starts from 0 on entry
            if (state_q != S_EXEC) cnt_q <= '0;
            else if (cnt_q != 6'h3f) cnt_q <= cnt_q + 6'd1;

            case (state_d)
                S_STORE: begin
                    fpu_enable <= 1'b0;
                    fpu_ld     <= 1'b0;
                    fpu_act    <= 1'b0;
                    fpu_addr1  <= sel[RD_LSB +: 5];
                    fpu_addr2  <= '0;
                    fpu_addr3  <= '0;
                    fpu_opcode <= '0;
                    fpu_inp    <= sel[DATA_LSB +: 32];
                end
                S_LOAD1, S_LOAD2, S_EXEC: begin
                    fpu_enable <= 1'b1;
                    fpu_ld     <= (state_d != S_EXEC);
                    fpu_act    <= 1'b1;
                    fpu_addr1  <= sel[RS1_LSB +: 5];
                    fpu_addr2  <= sel[RS2_LSB +: 5];
                    fpu_addr3  <= sel[RD_LSB +: 5];
                    fpu_opcode <= sel[OP_LSB +: 3];
                    fpu_inp    <= '0;
                end
                default: begin
                    fpu_enable <= 1'b0;
                    fpu_ld     <= 1'b0;
                    fpu_act    <= 1'b0;
                    fpu_addr1  <= PARK_ADDR;
                    fpu_addr2  <= '0;
                    fpu_addr3  <= '0;
                    fpu_opcode <= '0;
                    fpu_inp    <= '0;
                end
            endcase

            rsp_valid <= 1'b0;
            if (state_q == S_STORE) begin
                rsp_valid  <= 1'b1;
                rsp_result <= cur_q[DATA_LSB +: 32];
                rsp_cmp    <= '0;
                rsp_err    <= 1'b0;
            end else if (state_q == S_EXEC && fpu_done) begin
                rsp_valid  <= 1'b1;
                rsp_result <= fpu_out;
                rsp_cmp    <= (cur_q[OP_LSB +: 3] == OP_CMP) ? {fpu_great, fpu_eq, fpu_less} : 3'b000;
                rsp_err    <= 1'b0;
            end else if (state_q == S_ABORT) begin
                rsp_valid  <= 1'b1;
                rsp_result <= '0;
                rsp_cmp    <= '0;
                rsp_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: a behavioural FPU model, a command driver and a
// response scoreboard fed by an expected queue.
module tb_fpu_seq;
    import fpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rstp;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_data;
    logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
    logic [2:0]  fpu_opcode;
    logic        fpu_enable, fpu_ld, fpu_act;
    logic [31:0] fpu_inp, fpu_out;
    logic        fpu_done, fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero;
    logic        fpu_eq, fpu_less, fpu_great;
    logic        rsp_valid, rsp_err, clr_flags, busy;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_cmp;
    logic [6:0]  flags;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  cmp;
        logic        err;
        logic        flags_chk;
        logic [6:0]  flags;
        logic        addr_chk;
        logic [4:0]  addr3;
        logic        abort_chk;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        int          done_at;
        logic [31:0] out;
        logic [4:0]  fl;
        logic [2:0]  cmp;
    } mdl_t;

    exp_t        exp_q[$];
    mdl_t        mdl_q[$];
    mdl_t        cur_m;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          exec_cnt = 0;
    logic [4:0]  exec_addr3 = '0;
    logic [31:0] regs [32];

    fpu_seq dut (
        .clk(clk), .rstp(rstp),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_data(cmd_data),
        .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3),
        .fpu_opcode(fpu_opcode), .fpu_enable(fpu_enable), .fpu_ld(fpu_ld),
        .fpu_act(fpu_act), .fpu_inp(fpu_inp), .fpu_out(fpu_out), .fpu_done(fpu_done),
        .fpu_ov(fpu_ov), .fpu_un(fpu_un), .fpu_inv(fpu_inv), .fpu_inexact(fpu_inexact),
        .fpu_div_zero(fpu_div_zero), .fpu_eq(fpu_eq), .fpu_less(fpu_less),
        .fpu_great(fpu_great), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_cmp(rsp_cmp), .rsp_err(rsp_err), .flags(flags), .clr_flags(clr_flags),
        .busy(busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [2:0] c, input logic err);
        exp_t e;
        e        = '0;
        e.result = r;
        e.cmp    = c;
        e.err    = err;
        return e;
    endfunction

    // FPU model: done after done_at EXEC cycles, junk on outputs otherwise
    initial begin
        fpu_done = 1'b0;
        fpu_out  = '0;
        {fpu_div_zero, fpu_inexact, fpu_inv, fpu_un, fpu_ov} = 5'b0;
        {fpu_great, fpu_eq, fpu_less} = 3'b0;
        cur_m = '{255, 32'h0, 5'b0, 3'b0};
        forever begin
            @(negedge clk);
            fpu_done = 1'b0;
            fpu_out  = 32'hDEADBEEF;
            {fpu_div_zero, fpu_inexact, fpu_inv, fpu_un, fpu_ov} = 5'b0;
            {fpu_great, fpu_eq, fpu_less} = 3'b0;
            if (!rstp) begin
                exec_cnt = 0;
            end else if (fpu_enable && !fpu_ld) begin
                if (exec_cnt == 0) begin
                    if (mdl_q.size() > 0) cur_m = mdl_q.pop_front();
                    else cur_m = '{255, 32'h0, 5'b0, 3'b0};
                    exec_addr3 = fpu_addr3;
                end
                if (exec_cnt == cur_m.done_at) begin
                    fpu_done = 1'b1;
                    fpu_out  = cur_m.out;
                    {fpu_div_zero, fpu_inexact, fpu_inv, fpu_un, fpu_ov} = cur_m.fl;
                    {fpu_great, fpu_eq, fpu_less} = cur_m.cmp;
                end
                exec_cnt++;
            end else begin
                exec_cnt = 0;
            end
            if (rstp && !fpu_enable && fpu_addr1 != 5'd31) regs[fpu_addr1] = fpu_inp;
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstp && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%h expected=none (cycle %0d)", rsp_result, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", rsp_result, e.result);
                    chk("rsp_cmp", 32'(rsp_cmp), 32'(e.cmp));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.lat != 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    if (e.addr_chk) chk("exec_addr3", 32'(exec_addr3), 32'(e.addr3));
                    if (e.flags_chk) chk("rsp_flags", 32'(flags), 32'(e.flags));
                    if (e.abort_chk) begin
                        chk("abort_enable", 32'(fpu_enable), 32'd0);
                        chk("abort_addr1", 32'(fpu_addr1), 32'd31);
                    end
                end
            end
        end
    end

    // Driver: returns at the negedge after the accepting edge
    task automatic push(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] data, output int acc);
        int g;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_data = data;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0) && g < n) begin
            @(negedge clk);
            g++;
        end
        chk("wait_idle_pending", 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        int   a, g;
        exp_t e;
        rstp = 1'b0; cmd_valid = 1'b0; clr_flags = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_addr1", 32'(fpu_addr1), 32'd31);
        chk("reset_enable", 32'(fpu_enable), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rstp = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Store then add
        push(OP_STORE, 5'd1, 5'd0, 5'd0, 32'h3F800000, a);
        e = mk(32'h3F800000, 3'b000, 1'b0); e.lat = 3; e.acc = a; exp_q.push_back(e);
        push(OP_STORE, 5'd2, 5'd0, 5'd0, 32'h40000000, a);
        exp_q.push_back(mk(32'h40000000, 3'b000, 1'b0));
        wait_idle(50);
        chk("reg1_written", regs[1], 32'h3F800000);
        chk("reg2_written", regs[2], 32'h40000000);
        mdl_q.push_back('{3, 32'h40400000, 5'b0, 3'b111});
        push(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0, a);
        e = mk(32'h40400000, 3'b000, 1'b0); e.addr_chk = 1'b1; e.addr3 = 5'd3;
        e.lat = 8; e.acc = a; exp_q.push_back(e);
        wait_idle(50);

        // Compare
        mdl_q.push_back('{1, 32'h0, 5'b0, 3'b001});
        push(OP_CMP, 5'd5, 5'd1, 5'd2, 32'h0, a);
        e = mk(32'h0, 3'b001, 1'b0); e.flags_chk = 1'b1; e.flags = 7'b0; exp_q.push_back(e);
        wait_idle(50);

        // FIFO full behind a stalled div
        mdl_q.push_back('{20, 32'h3F000000, 5'b0, 3'b0});
        push(OP_DIV, 5'd6, 5'd1, 5'd2, 32'h0, a);
        exp_q.push_back(mk(32'h3F000000, 3'b000, 1'b0));
        repeat (4) @(negedge clk);
        push(OP_STORE, 5'd7, 5'd0, 5'd0, 32'h12345678, a);
        exp_q.push_back(mk(32'h12345678, 3'b000, 1'b0));
        mdl_q.push_back('{2, 32'h40400000, 5'b0, 3'b010});
        push(OP_ADD, 5'd8, 5'd1, 5'd2, 32'h0, a);
        e = mk(32'h40400000, 3'b000, 1'b0); e.addr_chk = 1'b1; e.addr3 = 5'd8; exp_q.push_back(e);
        mdl_q.push_back('{0, 32'h40000000, 5'b0, 3'b0});
        push(OP_MUL, 5'd9, 5'd1, 5'd2, 32'h0, a);
        exp_q.push_back(mk(32'h40000000, 3'b000, 1'b0));
        push(OP_STORE, 5'd10, 5'd0, 5'd0, 32'hCAFEF00D, a);
        exp_q.push_back(mk(32'hCAFEF00D, 3'b000, 1'b0));
        chk("cmd_ready_full", 32'(cmd_ready), 32'd0);
        mdl_q.push_back('{4, 32'h3F800000, 5'b0, 3'b0});
        push(OP_SQRT, 5'd11, 5'd1, 5'd0, 32'h0, a);
        exp_q.push_back(mk(32'h3F800000, 3'b000, 1'b0));
        wait_idle(300);

        // Timeout
        mdl_q.push_back('{1000, 32'h0, 5'b0, 3'b0});
        push(OP_MUL, 5'd12, 5'd1, 5'd2, 32'h0, a);
        e = mk(32'h0, 3'b000, 1'b1); e.lat = 37; e.acc = a;
        e.flags_chk = 1'b1; e.flags = 7'b1000000; e.abort_chk = 1'b1; exp_q.push_back(e);
        wait_idle(100);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("flags_clr_timeout", 32'(flags), 32'd0);

        // Illegal op then div by zero
        push(3'd6, 5'd0, 5'd0, 5'd0, 32'h0, a);
        mdl_q.push_back('{2, 32'h7F800000, 5'b10000, 3'b0});
        push(OP_DIV, 5'd13, 5'd1, 5'd0, 32'h0, a);
        e = mk(32'h7F800000, 3'b000, 1'b0); e.flags_chk = 1'b1; e.flags = 7'b0110000;
        exp_q.push_back(e);
        wait_idle(50);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("flags_clr_div", 32'(flags), 32'd0);

        // Reset mid-EXEC
        push(3'd7, 5'd0, 5'd0, 5'd0, 32'h0, a);
        mdl_q.push_back('{30, 32'h40000000, 5'b0, 3'b0});
        push(OP_MUL, 5'd14, 5'd1, 5'd2, 32'h0, a);
        exp_q.push_back(mk(32'h40000000, 3'b000, 1'b0));
        g = 0;
        while (exec_cnt < 3 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("mul_in_exec", 32'(exec_cnt >= 3), 32'd1);
        #2 rstp = 1'b0;
        #1;
        chk("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midreset_enable", 32'(fpu_enable), 32'd0);
        chk("midreset_ld_act", 32'({fpu_ld, fpu_act}), 32'd0);
        chk("midreset_addr1", 32'(fpu_addr1), 32'd31);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_flags", 32'(flags), 32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        mdl_q.delete();
        repeat (2) @(negedge clk);
        rstp = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_seq.md
# fpu_seq

Command sequencer for the single-precision `fpu` top level. It accepts register-level FP commands from a host over a valid/ready interface and buffers them in a small FIFO. For each command it drives the FPU's memory-port and control pins (`addr1/2/3`, `opcode_in`, `enable`, `ld`, `act`, `inp`) through load, execute and write-back. It returns the result, compare outcome and sticky IEEE exception flags to the host.

## Interface
- `DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `TIMEOUT`, 32: maximum EXEC cycles without `fpu_done` before abort.
- `PARK_ADDR`, 31: reserved register that absorbs FPU idle writes; never a valid `rd`.
- `clk` in 1: clock.
- `rstp` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; a transfer occurs when both are high.
- `cmd_op` in 3: 0 add, 1 mul, 2 div, 3 sqrt, 4 compare, 5 store, 6–7 illegal.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 5 each: destination and source registers.
- `cmd_data` in 32: store data (op 5 only).
- `fpu_addr1`, `fpu_addr2`, `fpu_addr3` out 5 each; `fpu_opcode` out 3; `fpu_enable`, `fpu_ld`, `fpu_act` out 1 each; `fpu_inp` out 32: FPU control.
- `fpu_out` in 32; `fpu_done`, `fpu_ov`, `fpu_un`, `fpu_inv`, `fpu_inexact`, `fpu_div_zero`, `fpu_eq`, `fpu_less`, `fpu_great` in 1 each: FPU status.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_result` out 32: result of the completed command.
- `rsp_cmp` out 3: compare outcome `{great,eq,less}`.
- `rsp_err` out 1: completed command aborted.
- `flags` out 7: sticky `{timeout, illegal, div_zero, inexact, inv, un, ov}`.
- `clr_flags` in 1: synchronous clear of `flags`.
- `busy` out 1: high when FSM is not IDLE or FIFO is non-empty.

## Operation
- FIFO entry is 50 bits `{op, rd, rs1, rs2, data}`. `cmd_ready = !full`. There is no bypass: a pushed entry is poppable the next cycle.
- FSM states: IDLE, STORE, LOAD1, LOAD2, EXEC, ABORT.
- IDLE
  - Outputs: `enable=0, ld=0, act=0, addr1=PARK_ADDR, inp=0`. The FPU writes `inp` to `addr1` whenever `enable=0`, so idle writes land only in PARK_ADDR.
  - If the FIFO is non-empty, pop one entry. Op 5 → STORE. Ops 0–4 → LOAD1. Ops 6–7 → set `flags[5]`, stay in IDLE, no response.
- STORE (1 cycle): `enable=0, addr1=rd, inp=data`. Then `rsp_valid` with `rsp_result=data`, → IDLE.
- LOAD1 / LOAD2: `enable=1, ld=1, act=1, addr1=rs1, addr2=rs2, addr3=rd, fpu_opcode=op`. The two cycles cover the SRAM read latency. `fpu_done` is ignored in these states. LOAD1 → LOAD2 → EXEC.
- EXEC: same outputs with `ld=0`. The FPU writes the result to `rd` on its done cycle.
  - On the cycle `fpu_done=1` is sampled: capture `fpu_out` into `rsp_result`, capture `{great,eq,less}` into `rsp_cmp` (op 4 only, otherwise 0), and OR `{div_zero,inexact,inv,un,ov}` into `flags[4:0]`. Pulse `rsp_valid`, → IDLE.
  - If the wait counter reaches TIMEOUT: → ABORT.
- ABORT (1 cycle): `enable=0, addr1=PARK_ADDR`. Set `flags[6]`; pulse `rsp_valid` with `rsp_err=1, rsp_result=0`. → IDLE.
- `clr_flags` takes priority over same-cycle flag sets.

## Timing
- All outputs are registered. Reset values:
  - `cmd_ready=0` during reset, 1 from the first clock after reset.
  - Every other output is 0, except `fpu_addr1=PARK_ADDR`.
  - FIFO empty, FSM in IDLE.
- Arithmetic op latency from pop to `rsp_valid` = 1 (IDLE pop) + 2 (LOAD) + N (EXEC cycles until `fpu_done`) + 1.
- Store latency from pop to `rsp_valid` = 2 cycles.
- Back-to-back commands: the next pop occurs in the IDLE cycle after `rsp_valid`. `fpu_enable` is low for at least one cycle between ops, which resets the FPU done counter.
- The EXEC wait counter is 6 bits, clears on entry to EXEC, and saturates.
- Asserting `rstp` mid-operation:
  - Flushes the FIFO, sets the FSM to IDLE and clears `flags`.
  - Any in-flight command is lost with no response.

## Structure
- Package `fpu_seq_pkg` holds:
  - opcode constants (`OP_ADD`…`OP_STORE`);
  - the FSM state enum;
  - the command entry width and field offsets;
  - the flag bit indices.
- Sub-module `fpu_seq_fifo`: synchronous FIFO parameterised by width and depth, with ptr+1-bit full/empty logic.

## Test plan
- **Store then add.**
  - Stimulus: store 0x3F800000→r1, store 0x40000000→r2, add r1,r2→r3; FPU model asserts done 3 cycles into EXEC.
  - Required: three `rsp_valid` pulses; add shows `fpu_addr3=3` and `rsp_result=0x40400000`. The add response arrives 7 cycles after its pop.
- **Compare.**
  - Stimulus: compare r1,r2 with model `{great,eq,less}=001`.
  - Required: `rsp_cmp=3'b001`, `rsp_result=0`.
- **FIFO full.**
  - Stimulus: push 5 commands back-to-back while a div is stalled.
  - Required: `cmd_ready` drops after the 4th push; all 5 complete in order.
- **Timeout.**
  - Stimulus: model never asserts `fpu_done`.
  - Required: after 32 EXEC cycles, `rsp_err=1`, `flags[6]=1`, `fpu_enable=0`, `fpu_addr1=31`.
- **Illegal op and flag clear.**
  - Stimulus: op 6, then a div returning `div_zero=1`.
  - Required: `flags=7'b0110000` after the div completes; `clr_flags` clears `flags` to 0 next cycle.
- **Reset mid-EXEC.**
  - Stimulus: assert `rstp=0` during a mul.
  - Required: outputs take their reset values immediately, `busy=0`, and no `rsp_valid` for the lost command.
